// File: rtl/mips_lsu_pkg.sv
// Shared constants and types for the MIPS load/store unit.
package mips_lsu_pkg;

  localparam int unsigned DEF_ADDR_W = 8;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_SW  = 3'd1;
  localparam logic [2:0] OP_LB  = 3'd2;
  localparam logic [2:0] OP_LBU = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4
  } state_t;

endpackage

// File: rtl/mips_lsu_byte_lane.sv
// Little-endian byte extract (sign/zero extend) and byte merge for sub-word accesses.
module mips_lsu_byte_lane (
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [7:0]  new_byte,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0] sel;

  always_comb begin
    sel    = '0;
    merged = word;
    unique case (lane)
      2'd0: begin sel = word[7:0];   merged[7:0]   = new_byte; end
      2'd1: begin sel = word[15:8];  merged[15:8]  = new_byte; end
      2'd2: begin sel = word[23:16]; merged[23:16] = new_byte; end
      default: begin sel = word[31:24]; merged[31:24] = new_byte; end
    endcase
    load_data = sign_ext ? {{24{sel[7]}}, sel} : {24'b0, sel};
  end

endmodule

// File: rtl/mips_lsu.sv
// Single-outstanding load/store unit: word and byte accesses to a registered data memory,
// with SB implemented as read-modify-write.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_d;
  logic [2:0]  op_q;
  logic [1:0]  lane_q;
  logic [7:0]  byte_q;

  logic        accept, req_bad, bad_range, bad_align, bad_op;
  logic        mem_read_d, mem_write_d, resp_valid_d, resp_err_d;
  logic [31:0] resp_rdata_d;
  logic [31:0] lane_load, lane_merged, load_result;

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid;

  assign bad_range = (req_addr >> (ADDR_W + 2)) != 32'd0;
  assign bad_align = ((req_op == OP_LW) || (req_op == OP_SW)) && (req_addr[1:0] != 2'b00);
  assign bad_op    = (req_op > OP_SB);
  assign req_bad   = bad_range || bad_align || bad_op;

  mips_lsu_byte_lane u_byte_lane (
    .word      (mem_rdata),
    .lane      (lane_q),
    .sign_ext  (op_q == OP_LB),
    .new_byte  (byte_q),
    .load_data (lane_load),
    .merged    (lane_merged)
  );

  assign load_result = (op_q == OP_LW) ? mem_rdata : lane_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_bad)              state_d = RESP;
          else if (req_op == OP_SW) state_d = WR;
          else                      state_d = RD;
        end
      end
      RD:      state_d = CAP;
      CAP:     state_d = (op_q == OP_SB) ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered strobes; validated non-SW ops always start with a read.
  always_comb begin
    mem_read_d   = accept && !req_bad && (req_op != OP_SW);
    mem_write_d  = (accept && !req_bad && (req_op == OP_SW)) ||
                   ((state == CAP) && (op_q == OP_SB));
    resp_valid_d = (state_d == RESP);
    resp_err_d   = accept && req_bad;
    resp_rdata_d = ((state == CAP) && (op_q != OP_SB)) ? load_result : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      mem_read   <= mem_read_d;
      mem_write  <= mem_write_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      lane_q    <= '0;
      byte_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if (accept) begin
        op_q     <= req_op;
        lane_q   <= req_addr[1:0];
        byte_q   <= req_wdata[7:0];
        mem_addr <= 32'(req_addr[ADDR_W+1:2]);
        if (!req_bad && (req_op == OP_SW)) mem_wdata <= req_wdata;
      end
      if ((state == CAP) && (op_q == OP_SB)) mem_wdata <= lane_merged;
    end
  end

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu with a registered-read data memory model.
module tb_mips_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] mem [0:255];

  logic        rv [0:5];
  logic        re [0:5];
  logic [31:0] rd [0:5];
  logic        mr [0:5];
  logic        mw [0:5];
  logic        rr [0:5];
  logic [31:0] wd [0:5];
  logic [31:0] ma [0:5];

  mips_lsu #(.ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drives one request, keeps req_valid high with junk for a cycle to show it is ignored,
  // and records outputs #1 after each of the following five edges (cycles 1..5).
  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    rr[0]     = req_ready;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        req_op    = 3'd1;
        req_addr  = 32'h0000_0000;
        req_wdata = 32'h5A5A_5A5A;
      end else begin
        req_valid = 1'b0;
      end
      rv[c] = resp_valid; re[c] = resp_err; rd[c] = resp_rdata;
      mr[c] = mem_read;   mw[c] = mem_write; rr[c] = req_ready;
      wd[c] = mem_wdata;  ma[c] = mem_addr;
    end
  endtask

  function automatic int unsigned strobes();
    int unsigned n = 0;
    for (int c = 1; c <= 5; c++) n += 32'(mr[c]) + 32'(mw[c]);
    return n;
  endfunction

  task automatic load_expect(input string tag, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] exp);
    issue(op, addr, 32'h0);
    check({tag, "_rd_strobe_c1"}, 32'(mr[1]), 32'd1);
    check({tag, "_rv_c2"}, 32'(rv[2]), 32'd0);
    check({tag, "_rv_c3"}, 32'(rv[3]), 32'd1);
    check({tag, "_err_c3"}, 32'(re[3]), 32'd0);
    check({tag, "_rdata_c3"}, rd[3], exp);
    check({tag, "_rv_c4"}, 32'(rv[4]), 32'd0);
  endtask

  task automatic error_expect(input string tag, input logic [2:0] op, input logic [31:0] addr);
    issue(op, addr, 32'hFFFF_FFFF);
    check({tag, "_rv_c1"}, 32'(rv[1]), 32'd1);
    check({tag, "_err_c1"}, 32'(re[1]), 32'd1);
    check({tag, "_rdata_c1"}, rd[1], 32'h0);
    check({tag, "_strobes"}, strobes(), 32'd0);
    check({tag, "_rv_c2"}, 32'(rv[2]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic wr_seen, rv_seen;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
    #12;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_mem_write", 32'(mem_write), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word store then load back
    issue(3'd1, 32'h10, 32'hDEAD_BEEF);
    check("sw_ready_c0", 32'(rr[0]), 32'd1);
    check("sw_ready_c1", 32'(rr[1]), 32'd0);
    check("sw_write_c1", 32'(mw[1]), 32'd1);
    check("sw_read_c1", 32'(mr[1]), 32'd0);
    check("sw_addr_c1", ma[1], 32'd4);
    check("sw_wdata_c1", wd[1], 32'hDEAD_BEEF);
    check("sw_rv_c1", 32'(rv[1]), 32'd0);
    check("sw_rv_c2", 32'(rv[2]), 32'd1);
    check("sw_rdata_c2", rd[2], 32'h0);
    check("sw_strobes", strobes(), 32'd1);
    load_expect("lw10", 3'd0, 32'h10, 32'hDEAD_BEEF);
    check("lw10_addr_c1", ma[1], 32'd4);
    check("lw10_strobes", strobes(), 32'd1);

    // Byte loads from one word, all lanes / both extensions
    issue(3'd1, 32'h20, 32'h80FF_7F01);
    load_expect("lb23", 3'd2, 32'h23, 32'hFFFF_FF80);
    load_expect("lb22", 3'd2, 32'h22, 32'hFFFF_FFFF);
    load_expect("lbu23", 3'd3, 32'h23, 32'h0000_0080);
    load_expect("lb21", 3'd2, 32'h21, 32'h0000_007F);
    load_expect("lbu20", 3'd3, 32'h20, 32'h0000_0001);
    load_expect("lbu22", 3'd3, 32'h22, 32'h0000_00FF);

    // Byte store read-modify-write
    issue(3'd1, 32'h30, 32'h1122_3344);
    issue(3'd4, 32'h31, 32'hFFFF_FFAA);
    check("sb_read_c1", 32'(mr[1]), 32'd1);
    check("sb_write_c2", 32'(mw[2]), 32'd0);
    check("sb_write_c3", 32'(mw[3]), 32'd1);
    check("sb_wdata_c3", wd[3], 32'h1122_AA44);
    check("sb_addr_c3", ma[3], 32'd12);
    check("sb_addr_c4", ma[4], 32'd12);
    check("sb_wdata_c5", wd[5], 32'h1122_AA44);
    check("sb_rv_c3", 32'(rv[3]), 32'd0);
    check("sb_rv_c4", 32'(rv[4]), 32'd1);
    check("sb_err_c4", 32'(re[4]), 32'd0);
    check("sb_rdata_c4", rd[4], 32'h0);
    check("sb_strobes", strobes(), 32'd2);
    load_expect("lw30", 3'd0, 32'h30, 32'h1122_AA44);
    issue(3'd4, 32'h33, 32'h0000_0000);
    load_expect("lw30b", 3'd0, 32'h30, 32'h0022_AA44);

    // Error cases
    error_expect("err_lw06", 3'd0, 32'h06);
    error_expect("err_sw400", 3'd1, 32'h400);
    error_expect("err_op6", 3'd6, 32'h0);
    error_expect("err_lb_oob", 3'd2, 32'h8000_0001);

    // Reset during SB merge cycle
    issue(3'd1, 32'h40, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_addr = 32'h41; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready), 32'd1);
    check("midrst_mem_read", 32'(mem_read), 32'd0);
    check("midrst_mem_addr", mem_addr, 32'h0);
    wr_seen = 1'b0; rv_seen = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    wr_seen |= mem_write; rv_seen |= resp_valid;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      wr_seen |= mem_write; rv_seen |= resp_valid;
    end
    check("midrst_no_write", 32'(wr_seen), 32'd0);
    check("midrst_no_resp", 32'(rv_seen), 32'd0);
    load_expect("midrst_lw40", 3'd0, 32'h40, 32'h1122_3344);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_lsu.md
MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core load/store request present
- req_ready  out  1  LSU can accept; high only in IDLE
- req_op  in  3  0=LW, 1=SW, 2=LB, 3=LBU, 4=SB; 5-7 reserved
- req_addr  in  32  byte address
- req_wdata  in  32  store data; SB uses bits [7:0]
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid: misaligned, out-of-range or reserved op
- mem_addr  out  32  word index to data memory, {24'b0, addr[9:2]}
- mem_wdata  out  32  word to memory
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_rdata  in  32  memory read word, registered by memory, valid the cycle after the mem_read cycle
REQ-002 SHALL have parameter ADDR_W, default 8, meaning word-index width (memory depth 2^ADDR_W words).

Function
REQ-003 SHALL accept a request on a rising edge with req_valid and req_ready both high; operands are latched at that edge (cycle 0).
REQ-004 SHALL use FSM states IDLE, RD, CAP, WR, RESP; req_ready = (state == IDLE).
REQ-005 SHALL flag an error if req_addr[31:ADDR_W+2] != 0, if LW/SW has addr[1:0] != 0, or if req_op is reserved; on error: IDLE->RESP, no memory strobe, resp_valid=1 and resp_err=1 in cycle 1, resp_rdata=0.
REQ-006 LW/LB/LBU SHALL follow IDLE->RD->CAP->RESP: mem_read=1 in cycle 1, capture mem_rdata at the end of cycle 2, resp_valid in cycle 3.
REQ-007 SW SHALL follow IDLE->WR->RESP: mem_write=1 and mem_wdata=req_wdata in cycle 1, resp_valid in cycle 2.
REQ-008 SB SHALL read-modify-write via IDLE->RD->CAP->WR->RESP: read in cycle 1, merge in cycle 2, mem_write in cycle 3, resp_valid in cycle 4.
REQ-009 Byte lane SHALL be addr[1:0], little-endian (lane k = bits [8k+7:8k]); LB sign-extends, LBU zero-extends; SB replaces only lane k and preserves the other three bytes.
REQ-010 SHALL drive mem_read, mem_write, resp_valid and resp_err from registers; at most one of mem_read and mem_write is high in any cycle.
REQ-011 SHALL hold mem_addr and mem_wdata stable from the strobe cycle until the next accepted request.
REQ-012 SHALL return RESP->IDLE unconditionally; there is no response backpressure, and back-to-back accepts are spaced by at least one IDLE cycle.
REQ-013 SHALL ignore req_valid and all request inputs while not in IDLE.

Reset
REQ-014 rst_n low SHALL force, asynchronously: state=IDLE, mem_read=0, mem_write=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0; req_ready=1.
REQ-015 Reset mid-operation SHALL abort with no response; a pending SB write SHALL NOT reach memory.

Structure
REQ-016 Package mips_lsu_pkg SHALL hold the op-code constants, the FSM state enum and the default ADDR_W.
REQ-017 Byte extract, sign-extend and merge logic SHALL live in combinational sub-module mips_lsu_byte_lane.

Verification
REQ-018 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_write in cycle 1 with mem_addr=4; LW resp_rdata=0xDEADBEEF in cycle 3, resp_err=0.
REQ-019 Word 0x80FF7F01 at 0x20; LB 0x23, LB 0x22, LBU 0x23 -> 0xFFFFFF80, 0xFFFFFFFF, 0x00000080.
REQ-020 Word 0x11223344 at 0x30; SB 0x31 data 0xAA -> mem_wdata=0x1122AA44 with mem_write in cycle 3; later LW 0x30 returns 0x1122AA44.
REQ-021 LW 0x06, SW 0x400 and op 6 -> each gives resp_err=1 and resp_rdata=0 in cycle 1, with no mem_read or mem_write.
REQ-022 SB accepted, rst_n pulsed low in cycle 2 -> mem_write never asserts, no resp_valid, and a following LW returns the original word.
